// File: rtl/regfile_operand_fetch_if.sv
// Bus bundle for regfile_operand_fetch: control-unit request, register-file
// read/write-snoop ports and the A/B operand handshake toward the ALU stage.
interface regfile_operand_fetch_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 16
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_rs;
    logic [ADDR_W-1:0] req_rt;

    logic [ADDR_W-1:0] rf_rs;
    logic [ADDR_W-1:0] rf_rt;
    logic [DATA_W-1:0] rf_data1;
    logic [DATA_W-1:0] rf_data2;

    logic              wb_wre;
    logic [ADDR_W-1:0] wb_reg;
    logic [DATA_W-1:0] wb_data;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic [ADDR_W-1:0] out_rs;
    logic [ADDR_W-1:0] out_rt;
    logic [CNT_W-1:0]  fetch_cnt;

    modport slave (
        input  req_valid, req_rs, req_rt,
        input  rf_data1, rf_data2,
        input  wb_wre, wb_reg, wb_data,
        input  out_ready,
        output req_ready, rf_rs, rf_rt,
        output out_valid, A, B, out_rs, out_rt, fetch_cnt
    );

    modport master (
        output req_valid, req_rs, req_rt,
        output rf_data1, rf_data2,
        output wb_wre, wb_reg, wb_data,
        output out_ready,
        input  req_ready, rf_rs, rf_rt,
        input  out_valid, A, B, out_rs, out_rt, fetch_cnt
    );
endinterface

// File: rtl/regfile_operand_fetch.sv
// Operand fetch: latches rs/rt, reads the register file, holds A/B for the ALU.
// Optional macro OPFETCH_SNOOP_EN: refresh held A/B from register-file writes in HOLD.
module regfile_operand_fetch #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 16
) (
    input logic                    CLK,
    input logic                    Reset,
    regfile_operand_fetch_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] rs_q, rs_d;
    logic [ADDR_W-1:0] rt_q, rt_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [ADDR_W-1:0] out_rs_q, out_rs_d;
    logic [ADDR_W-1:0] out_rt_q, out_rt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ready_q, ready_d;
    logic              valid_q, valid_d;

    // State and datapath registers; ready/valid are registered decodes of next state.
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state_q  <= ST_IDLE;
            rs_q     <= '0;
            rt_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            out_rs_q <= '0;
            out_rt_q <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            out_rs_q <= out_rs_d;
            out_rt_q <= out_rt_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        rs_d     = rs_q;
        rt_d     = rt_q;
        a_d      = a_q;
        b_d      = b_q;
        out_rs_d = out_rs_q;
        out_rt_d = out_rt_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    rs_d    = bus.req_rs;
                    rt_d    = bus.req_rt;
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                // r0 reads as zero regardless of what the file returns.
                a_d      = (rs_q == '0) ? '0 : bus.rf_data1;
                b_d      = (rt_q == '0) ? '0 : bus.rf_data2;
                out_rs_d = rs_q;
                out_rt_d = rt_q;
                state_d  = ST_HOLD;
            end
            ST_HOLD: begin
`ifdef OPFETCH_SNOOP_EN
                if (bus.wb_wre && (bus.wb_reg != '0)) begin
                    if (bus.wb_reg == out_rs_q) a_d = bus.wb_data;
                    if (bus.wb_reg == out_rt_q) b_d = bus.wb_data;
                end
`endif
                if (bus.out_ready) begin
                    cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_IDLE);
        valid_d = (state_d == ST_HOLD);
    end

`ifndef OPFETCH_SNOOP_EN
    logic unused_wb;
    assign unused_wb = ^{bus.wb_wre, bus.wb_reg, bus.wb_data};
`endif

    assign bus.req_ready = ready_q;
    assign bus.out_valid = valid_q;
    assign bus.rf_rs     = rs_q;
    assign bus.rf_rt     = rt_q;
    assign bus.A         = a_q;
    assign bus.B         = b_q;
    assign bus.out_rs    = out_rs_q;
    assign bus.out_rt    = out_rt_q;
    assign bus.fetch_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_operand_fetch.sv
// Scoreboard bench for regfile_operand_fetch with a negedge-write register-file model.
module tb_regfile_operand_fetch;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned CNT_W  = 4;

`ifdef OPFETCH_SNOOP_EN
    localparam logic [DATA_W-1:0] HOLD_B = 32'h0000_1234;
`else
    localparam logic [DATA_W-1:0] HOLD_B = 32'h0000_0099;
`endif

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [ADDR_W-1:0] rs;
        logic [ADDR_W-1:0] rt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    regfile_operand_fetch_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    regfile_operand_fetch #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .CLK   (clk),
        .Reset (rst_n),
        .bus   (bus.slave)
    );

    // Register file model: combinational read, write on negedge; r0 deliberately non-zero.
    logic [DATA_W-1:0] regs [32];
    assign bus.rf_data1 = regs[bus.rf_rs];
    assign bus.rf_data2 = regs[bus.rf_rt];
    always @(negedge clk) if (bus.wb_wre) regs[bus.wb_reg] = bus.wb_data;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every completed output handshake pops and checks one expected entry.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_handshake", 32'(bus.out_valid), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("mon_A", bus.A, e.a);
                chk("mon_B", bus.B, e.b);
                chk("mon_out_rs", 32'(bus.out_rs), 32'(e.rs));
                chk("mon_out_rt", 32'(bus.out_rt), 32'(e.rt));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus.req_ready && n < 20) begin
            tick();
            n++;
        end
        chk("ready_wait", 32'(bus.req_ready), 32'd1);
    endtask

    // Issue one request; returns one step into HOLD.
    task automatic fetch(input logic [ADDR_W-1:0] rs, input logic [ADDR_W-1:0] rt,
                         input logic [DATA_W-1:0] ea, input logic [DATA_W-1:0] eb,
                         input logic sw, input logic [ADDR_W-1:0] swreg,
                         input logic [DATA_W-1:0] swdata);
        exp_t e;
        e.a = ea; e.b = eb; e.rs = rs; e.rt = rt;
        exp_q.push_back(e);
        wait_ready();
        bus.req_valid = 1'b1;
        bus.req_rs    = rs;
        bus.req_rt    = rt;
        tick();
        bus.req_valid = 1'b0;
        bus.req_rs    = 5'd31;
        bus.req_rt    = 5'd30;
        chk("sample_valid", 32'(bus.out_valid), 32'd0);
        chk("sample_ready", 32'(bus.req_ready), 32'd0);
        chk("rf_rs", 32'(bus.rf_rs), 32'(rs));
        chk("rf_rt", 32'(bus.rf_rt), 32'(rt));
        if (sw) begin
            bus.wb_wre  = 1'b1;
            bus.wb_reg  = swreg;
            bus.wb_data = swdata;
        end
        tick();
        bus.wb_wre = 1'b0;
        chk("hold_valid", 32'(bus.out_valid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'(32'h100 + i);
        regs[0] = 32'hDEAD_BEEF;
        regs[3] = 32'h11;
        regs[4] = 32'h22;
        regs[7] = 32'h77;
        regs[9] = 32'h99;
        bus.req_valid = 1'b0;
        bus.req_rs    = '0;
        bus.req_rt    = '0;
        bus.wb_wre    = 1'b0;
        bus.wb_reg    = '0;
        bus.wb_data   = '0;
        bus.out_ready = 1'b0;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_A", bus.A, 32'd0);
        chk("rst_B", bus.B, 32'd0);
        chk("rst_out_rs", 32'(bus.out_rs), 32'd0);
        chk("rst_rf_rs", 32'(bus.rf_rs), 32'd0);
        chk("rst_cnt", 32'(bus.fetch_cnt), 32'd0);

        // Basic fetch, then r0 on either side, then a write landing during SAMPLE.
        bus.out_ready = 1'b1;
        fetch(5'd3, 5'd4, 32'h11, 32'h22, 1'b0, 5'd0, 32'd0);
        tick();
        chk("cnt_after_basic", 32'(bus.fetch_cnt), 32'd1);
        chk("idle_after_basic", 32'(bus.req_ready), 32'd1);

        fetch(5'd0, 5'd4, 32'h0, 32'h22, 1'b0, 5'd0, 32'd0);
        tick();
        fetch(5'd3, 5'd0, 32'h11, 32'h0, 1'b0, 5'd0, 32'd0);
        tick();
        chk("cnt_after_zero", 32'(bus.fetch_cnt), 32'd3);

        fetch(5'd5, 5'd5, 32'hCAFE, 32'hCAFE, 1'b1, 5'd5, 32'hCAFE);
        tick();
        chk("cnt_after_wsample", 32'(bus.fetch_cnt), 32'd4);

        // Stall in HOLD: write to r0, write to rt, and a request that must be ignored.
        bus.out_ready = 1'b0;
        fetch(5'd0, 5'd9, 32'h0, HOLD_B, 1'b0, 5'd0, 32'd0);
        bus.req_valid = 1'b1;
        bus.req_rs    = 5'd1;
        bus.req_rt    = 5'd2;
        bus.wb_wre    = 1'b1;
        bus.wb_reg    = 5'd0;
        bus.wb_data   = 32'h5555;
        tick();
        chk("r0_write_A", bus.A, 32'h0);
        chk("r0_write_B", bus.B, 32'h99);
        chk("busy_ignored_rf_rs", 32'(bus.rf_rs), 32'd0);
        bus.wb_reg  = 5'd9;
        bus.wb_data = 32'h1234;
        tick();
        bus.wb_wre = 1'b0;
        chk("snoop_B", bus.B, HOLD_B);
        chk("snoop_A", bus.A, 32'h0);
        tick();
        tick();
        chk("stall_valid", 32'(bus.out_valid), 32'd1);
        chk("stall_B", bus.B, HOLD_B);
        chk("stall_out_rt", 32'(bus.out_rt), 32'd9);
        bus.req_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("cnt_after_hold", 32'(bus.fetch_cnt), 32'd5);
        chk("idle_after_hold", 32'(bus.req_ready), 32'd1);

        // Back-to-back with req_valid held: acceptances every 3 cycles, counter saturates.
        bus.req_valid = 1'b1;
        bus.req_rs    = 5'd3;
        bus.req_rt    = 5'd4;
        for (int k = 0; k < 18; k++) begin
            exp_t e;
            int n;
            e.a = 32'h11; e.b = 32'h22; e.rs = 5'd3; e.rt = 5'd4;
            exp_q.push_back(e);
            n = 0;
            while (!bus.req_ready && n < 10) begin
                tick();
                n++;
            end
            chk("b2b_gap", 32'(n), (k == 0) ? 32'd0 : 32'd2);
            tick();
        end
        bus.req_valid = 1'b0;
        tick();
        tick();
        chk("cnt_saturated", 32'(bus.fetch_cnt), 32'hF);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        // Reset while holding an operand pair.
        bus.out_ready = 1'b0;
        fetch(5'd7, 5'd7, 32'h77, 32'h77, 1'b0, 5'd0, 32'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        chk("hrst_valid", 32'(bus.out_valid), 32'd0);
        chk("hrst_A", bus.A, 32'd0);
        chk("hrst_B", bus.B, 32'd0);
        chk("hrst_cnt", 32'(bus.fetch_cnt), 32'd0);
        chk("hrst_ready", 32'(bus.req_ready), 32'd1);
        chk("hrst_rf_rt", 32'(bus.rf_rt), 32'd0);

        bus.out_ready = 1'b1;
        fetch(5'd4, 5'd3, 32'h22, 32'h11, 1'b0, 5'd0, 32'd0);
        tick();
        chk("cnt_after_reset", 32'(bus.fetch_cnt), 32'd1);
        chk("final_queue", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
